// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed byte-stream image loader that fills instruction memory and releases the CPU
module boot_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_wen,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_data,
    output logic        cpu_run,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CSUM    = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);
    localparam logic [15:0] TO_W  = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] idle_q, idle_d;
    logic [15:0] words_q, words_d;
    logic        rx_ready_q, rx_ready_d;
    logic        wen_q, wen_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        run_q, run_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic        acc;
    logic        timed;
    logic [15:0] len_w;

    assign acc   = rx_valid & rx_ready_q;
    assign timed = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
    assign len_w = {len_hi_q, rx_data};

    // Frame parser: next state, checksum, word assembly and next values of every registered output
    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        data_hi_d = data_hi_q;
        csum_d    = csum_q;
        words_d   = words_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        code_d    = code_q;
        idle_d    = '0;

        case (state_q)
            S_SYNC: begin
                if (acc && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN_HI;
                    csum_d  = '0;
                    words_d = '0;
                end
            end
            S_LEN_HI: begin
                if (acc) begin
                    len_hi_d = rx_data;
                    csum_d   = csum_q + rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (acc) begin
                    len_d  = len_w;
                    csum_d = csum_q + rx_data;
                    if ({1'b0, len_w} > MAX_W) begin
                        state_d = S_ERROR;
                        code_d  = 2'b01;
                    end else if (len_w == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (acc) begin
                    data_hi_d = rx_data;
                    csum_d    = csum_q + rx_data;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (acc) begin
                    wen_d   = 1'b1;
                    data_d  = {data_hi_q, rx_data};
                    addr_d  = {words_q[14:0], 1'b0};
                    words_d = words_q + 16'd1;
                    csum_d  = csum_q + rx_data;
                    state_d = (words_q + 16'd1 == len_q) ? S_CSUM : S_DATA_HI;
                end
            end
            S_CSUM: begin
                if (acc) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                        code_d  = 2'b10;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_SYNC;
                    words_d = '0;
                    csum_d  = '0;
                end
            end
            S_ERROR: begin
                if (start) begin
                    state_d = S_SYNC;
                    code_d  = 2'b00;
                    words_d = '0;
                    csum_d  = '0;
                end
            end
            default: state_d = S_SYNC;
        endcase

        // A byte arriving on the expiry cycle takes priority over the timeout
        if (timed && !acc && idle_q == TO_W) begin
            state_d = S_ERROR;
            code_d  = 2'b11;
        end

        if (timed && !acc && state_d == state_q) begin
            idle_d = idle_q + 16'd1;
        end

        rx_ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
        busy_d     = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
        err_d      = (state_d == S_ERROR);
        run_d      = (state_d == S_DONE);
    end

    // State and output registers; asynchronous reset parks the loader in SYNC with everything low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_SYNC;
            len_hi_q   <= '0;
            len_q      <= '0;
            data_hi_q  <= '0;
            csum_q     <= '0;
            idle_q     <= '0;
            words_q    <= '0;
            rx_ready_q <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            data_hi_q  <= data_hi_d;
            csum_q     <= csum_d;
            idle_q     <= idle_d;
            words_q    <= words_d;
            rx_ready_q <= rx_ready_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_wen     = wen_q;
    assign imem_addr    = addr_q;
    assign imem_data    = data_q;
    assign cpu_run      = run_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign err_code     = code_q;
    assign words_loaded = words_q;

endmodule
